// File: rtl/ibexc_rvfi_trace_buffer_if.sv
// RVFI retirement stream and drain handshake bundle for the trace buffer.
// Signal suffixes are from the trace buffer's point of view.
interface ibexc_rvfi_trace_buffer_if;
  logic         rvfi_valid_i;
  logic [63:0]  rvfi_order_i;
  logic [31:0]  rvfi_pc_rdata_i;
  logic [31:0]  rvfi_insn_i;
  logic         rvfi_trap_i;
  logic         rvfi_intr_i;
  logic [4:0]   rvfi_rd_addr_i;
  logic [31:0]  rvfi_rd_wdata_i;
  logic         drain_valid_o;
  logic         drain_ready_i;
  logic [102:0] drain_data_o;

  // Core/tracer side plus debug consumer: drives retirements, accepts drained entries.
  modport master (
    output rvfi_valid_i, rvfi_order_i, rvfi_pc_rdata_i, rvfi_insn_i,
           rvfi_trap_i, rvfi_intr_i, rvfi_rd_addr_i, rvfi_rd_wdata_i,
           drain_ready_i,
    input  drain_valid_o, drain_data_o
  );

  // Trace buffer side.
  modport slave (
    input  rvfi_valid_i, rvfi_order_i, rvfi_pc_rdata_i, rvfi_insn_i,
           rvfi_trap_i, rvfi_intr_i, rvfi_rd_addr_i, rvfi_rd_wdata_i,
           drain_ready_i,
    output drain_valid_o, drain_data_o
  );
endinterface

// File: rtl/ibexc_rvfi_trace_buffer.sv
// Circular capture buffer for the CHERIoT Ibex RVFI retirement stream.
// Capture modes: continuous wrap, stop-on-full, trigger with post count.
// Stopped buffers drain oldest-first through a registered RAM read with a
// one-entry output register so back-to-back transfers sustain one per cycle.
// Optional retirement order gap detection: define IBEXC_TRACE_ORDER_CHK_EN.
module ibexc_rvfi_trace_buffer #(
  parameter int unsigned Depth           = 64,
  parameter int unsigned PostTrigDefault = 16,
  parameter int unsigned CntW            = $clog2(Depth) + 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  ibexc_rvfi_trace_buffer_if.slave bus,
  input  logic                  arm_i,
  input  logic                  stop_i,
  input  logic [1:0]            mode_i,
  input  logic [31:0]           trig_pc_i,
  input  logic                  trig_on_trap_i,
  input  logic [CntW-1:0]       post_cnt_i,
  output logic [CntW-1:0]       count_o,
  output logic [1:0]            state_o,
  output logic                  wrapped_o,
  output logic                  triggered_o,
  output logic                  order_err_o
);

  localparam int unsigned AW = $clog2(Depth);
  localparam logic [CntW-1:0] DepthCnt   = CntW'(Depth);
  localparam logic [CntW-1:0] DepthM1Cnt = CntW'(Depth - 1);
  localparam logic [CntW-1:0] PostDefCnt = CntW'(PostTrigDefault);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CAPT = 2'd1,
    POST = 2'd2,
    STOP = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   wptr_q, wptr_d;
  logic [AW-1:0]   rptr_q, rptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic [CntW-1:0] post_q, post_d;
  logic            wrapped_q, wrapped_d;
  logic            triggered_q, triggered_d;
  logic            dvalid_q, dvalid_d;
  logic [102:0]    dout_q;

  logic [102:0]    mem [Depth];
  logic [102:0]    wr_entry;
  logic            mem_we;
  logic            rd_en;
  logic [AW-1:0]   rd_addr;
  logic [1:0]      mode_eff;
  logic            capturing;
  logic            full;
  logic            trig_hit;
  logic            xfer;

  assign wr_entry  = {bus.rvfi_trap_i, bus.rvfi_intr_i, bus.rvfi_rd_addr_i,
                      bus.rvfi_pc_rdata_i, bus.rvfi_insn_i, bus.rvfi_rd_wdata_i};
  // Reserved mode 3 behaves like continuous capture.
  assign mode_eff  = (mode_i == 2'd3) ? 2'd0 : mode_i;
  assign capturing = (state_q == CAPT) || (state_q == POST);
  assign full      = (count_q == DepthCnt);
  assign trig_hit  = (bus.rvfi_pc_rdata_i == trig_pc_i) || (trig_on_trap_i && bus.rvfi_trap_i);

  // Next-state, pointer, count and drain-prefetch control.
  always_comb begin
    state_d     = state_q;
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    count_d     = count_q;
    post_d      = post_q;
    wrapped_d   = wrapped_q;
    triggered_d = triggered_q;
    dvalid_d    = dvalid_q;
    mem_we      = 1'b0;
    rd_en       = 1'b0;
    rd_addr     = rptr_q;
    xfer        = 1'b0;

    if (arm_i) begin
      // Restart wins over everything, including a simultaneous stop and any pending drain entry.
      state_d     = CAPT;
      wptr_d      = '0;
      rptr_d      = '0;
      count_d     = '0;
      post_d      = '0;
      wrapped_d   = 1'b0;
      triggered_d = 1'b0;
      dvalid_d    = 1'b0;
    end else if (capturing) begin
      dvalid_d = 1'b0;
      // A full stop-on-full buffer never overwrites.
      if (bus.rvfi_valid_i && !(mode_eff == 2'd1 && full)) begin
        mem_we = 1'b1;
        wptr_d = wptr_q + 1'b1;
        if (full) begin
          rptr_d    = rptr_q + 1'b1;
          wrapped_d = 1'b1;
        end else begin
          count_d = count_q + 1'b1;
        end
        if (state_q == POST) begin
          post_d = post_q - 1'b1;
          if (post_q == {{(CntW-1){1'b0}}, 1'b1}) state_d = STOP;
        end else if (mode_eff == 2'd1 && count_q == DepthM1Cnt) begin
          state_d = STOP;
        end else if (mode_eff == 2'd2 && trig_hit) begin
          triggered_d = 1'b1;
          post_d      = (post_cnt_i == '0) ? PostDefCnt : post_cnt_i;
          state_d     = POST;
        end
      end
      if (stop_i) state_d = STOP;
    end else begin
      // IDLE/STOP: the output register holds the entry at rptr; refill it from
      // the following address whenever it is empty or being consumed.
      xfer = dvalid_q && bus.drain_ready_i;
      if (xfer) begin
        rptr_d  = rptr_q + 1'b1;
        count_d = count_q - 1'b1;
      end
      rd_addr = rptr_d;
      if (!dvalid_q || xfer) begin
        rd_en    = (count_d != '0);
        dvalid_d = (count_d != '0);
      end
    end
  end

  // Control and pointer registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
      post_q      <= '0;
      wrapped_q   <= 1'b0;
      triggered_q <= 1'b0;
      dvalid_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      count_q     <= count_d;
      post_q      <= post_d;
      wrapped_q   <= wrapped_d;
      triggered_q <= triggered_d;
      dvalid_q    <= dvalid_d;
    end
  end

  // Capture storage; contents are not reset so it maps onto block RAM.
  always_ff @(posedge clk_i) begin
    if (mem_we) mem[wptr_q] <= wr_entry;
  end

  // Registered RAM read into the drain output register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      dout_q <= '0;
    end else if (rd_en) begin
      dout_q <= mem[rd_addr];
    end
  end

  assign bus.drain_valid_o = dvalid_q;
  assign bus.drain_data_o  = dout_q;
  assign count_o           = count_q;
  assign state_o           = state_q;
  assign wrapped_o         = wrapped_q;
  assign triggered_o       = triggered_q;

`ifdef IBEXC_TRACE_ORDER_CHK_EN
  logic [63:0] last_order_q, last_order_d;
  logic        first_q, first_d;
  logic        order_err_q, order_err_d;

  // Flag any retirement whose order does not follow the previous one; the
  // first retirement after arm only seeds the tracker.
  always_comb begin
    last_order_d = last_order_q;
    first_d      = first_q;
    order_err_d  = order_err_q;
    if (arm_i) begin
      first_d     = 1'b1;
      order_err_d = 1'b0;
    end else if (capturing && bus.rvfi_valid_i) begin
      if (!first_q && (bus.rvfi_order_i != last_order_q + 64'd1)) order_err_d = 1'b1;
      last_order_d = bus.rvfi_order_i;
      first_d      = 1'b0;
    end
  end

  // Order tracker registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      last_order_q <= '0;
      first_q      <= 1'b1;
      order_err_q  <= 1'b0;
    end else begin
      last_order_q <= last_order_d;
      first_q      <= first_d;
      order_err_q  <= order_err_d;
    end
  end

  assign order_err_o = order_err_q;
`else
  logic unused_order;
  assign unused_order = ^bus.rvfi_order_i;
  assign order_err_o  = 1'b0;
`endif

endmodule

// File: tb/tb_ibexc_rvfi_trace_buffer.sv
// Self-checking bench for ibexc_rvfi_trace_buffer: queue-based reference model
// checked every cycle, directed scenarios with literal expectations, then
// randomized capture/drain rounds.
module tb_ibexc_rvfi_trace_buffer;
  localparam int D    = 64;
  localparam int CW   = $clog2(D) + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          arm = 1'b0, stop = 1'b0, trig_on_trap = 1'b0;
  logic [1:0]    mode = 2'd0;
  logic [31:0]   trig_pc = '0;
  logic [CW-1:0] post_cnt = '0;
  logic [CW-1:0] count;
  logic [1:0]    state;
  logic          wrapped, triggered, order_err;

  int total = 0;
  int bad   = 0;

  ibexc_rvfi_trace_buffer_if bus();

  ibexc_rvfi_trace_buffer #(.Depth(D), .PostTrigDefault(16)) dut (
    .clk_i(clk), .rst_ni(rst_n), .bus(bus),
    .arm_i(arm), .stop_i(stop), .mode_i(mode), .trig_pc_i(trig_pc),
    .trig_on_trap_i(trig_on_trap), .post_cnt_i(post_cnt),
    .count_o(count), .state_o(state), .wrapped_o(wrapped),
    .triggered_o(triggered), .order_err_o(order_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [102:0] mq[$];
  int           m_st = 0;
  bit           m_wrapped = 0, m_trig = 0, m_valid = 0;
  int           m_post = 0;
  bit           m_first = 1, m_err = 0;
  logic [63:0]  m_last = '0;
  bit           cmp_en = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete(); m_st = 0; m_wrapped = 0; m_trig = 0; m_valid = 0;
      m_post = 0; m_first = 1; m_err = 0; m_last = '0;
    end else if (arm) begin
      mq.delete(); m_st = 1; m_wrapped = 0; m_trig = 0; m_valid = 0;
      m_post = 0; m_first = 1; m_err = 0;
    end else if (m_st == 1 || m_st == 2) begin
      int nst; int md;
      nst = m_st;
      md = (mode == 2'd3) ? 0 : int'(mode);
      if (bus.rvfi_valid_i) begin
        if (!m_first && bus.rvfi_order_i != m_last + 64'd1) m_err = 1;
        m_last = bus.rvfi_order_i; m_first = 0;
        if (!(md == 1 && mq.size() == D)) begin
          if (mq.size() == D) begin void'(mq.pop_front()); m_wrapped = 1; end
          mq.push_back({bus.rvfi_trap_i, bus.rvfi_intr_i, bus.rvfi_rd_addr_i,
                        bus.rvfi_pc_rdata_i, bus.rvfi_insn_i, bus.rvfi_rd_wdata_i});
          if (m_st == 2) begin
            m_post--;
            if (m_post == 0) nst = 3;
          end else if (md == 1 && mq.size() == D) begin
            nst = 3;
          end else if (md == 2 && (bus.rvfi_pc_rdata_i == trig_pc ||
                                   (trig_on_trap && bus.rvfi_trap_i))) begin
            m_trig = 1;
            m_post = (post_cnt == 0) ? 16 : int'(post_cnt);
            nst = 2;
          end
        end
      end
      if (stop) nst = 3;
      m_st = nst;
      m_valid = 0;
    end else begin
      if (m_valid && bus.drain_ready_i) void'(mq.pop_front());
      m_valid = (mq.size() > 0);
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("state", 128'(state), 128'(m_st));
      chk("count", 128'(count), 128'(mq.size()));
      chk("wrapped", 128'(wrapped), 128'(m_wrapped));
      chk("triggered", 128'(triggered), 128'(m_trig));
      chk("drain_valid", 128'(bus.drain_valid_o), 128'(m_valid));
      if (m_valid && mq.size() > 0) chk("drain_data", 128'(bus.drain_data_o), 128'(mq[0]));
`ifdef IBEXC_TRACE_ORDER_CHK_EN
      chk("order_err", 128'(order_err), 128'(m_err));
`else
      chk("order_err", 128'(order_err), 128'(0));
`endif
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic quiet();
    bus.rvfi_valid_i = 1'b0; arm = 1'b0; stop = 1'b0;
  endtask

  task automatic do_arm(input logic [1:0] md);
    mode = md; arm = 1'b1; cyc(); arm = 1'b0;
  endtask

  task automatic set_ret(input logic [31:0] pc, input logic [63:0] ord, input logic trap);
    bus.rvfi_valid_i    = 1'b1;
    bus.rvfi_pc_rdata_i = pc;
    bus.rvfi_order_i    = ord;
    bus.rvfi_insn_i     = $urandom;
    bus.rvfi_rd_wdata_i = $urandom;
    bus.rvfi_rd_addr_i  = 5'($urandom);
    bus.rvfi_trap_i     = trap;
    bus.rvfi_intr_i     = 1'($urandom);
  endtask

  task automatic retire(input logic [31:0] pc, input logic [63:0] ord);
    set_ret(pc, ord, 1'b0); cyc(); bus.rvfi_valid_i = 1'b0;
  endtask

  // Drain with ready held high; reports entry count, first/last PC and
  // whether PCs were consecutive (step 4).
  task automatic drain_all(output int n, output logic [31:0] first_pc,
                           output logic [31:0] last_pc, output bit seq_ok);
    logic [31:0] pc;
    bit done;
    n = 0; first_pc = '0; last_pc = '0; seq_ok = 1; done = 0;
    bus.drain_ready_i = 1'b1;
    for (int i = 0; i < 300 && !done; i++) begin
      if (bus.drain_valid_o) begin
        pc = bus.drain_data_o[95:64];
        if (n == 0) first_pc = pc;
        else if (pc != last_pc + 32'd4) seq_ok = 0;
        last_pc = pc; n++;
      end else if (n > 0 && count == 0) begin
        done = 1;
      end
      if (!done) cyc();
    end
    chk("drain_terminated", 128'(done), 128'(1));
    bus.drain_ready_i = 1'b0;
  endtask

  int          n;
  logic [31:0] fpc, lpc, pa, pb;
  bit          sok;

  initial begin
    quiet();
    bus.drain_ready_i = 1'b0;
    set_ret('0, '0, 1'b0); bus.rvfi_valid_i = 1'b0;
    repeat (3) cyc();
    chk("reset_state", 128'(state), 128'(0));
    chk("reset_count", 128'(count), 128'(0));
    chk("reset_valid", 128'(bus.drain_valid_o), 128'(0));
    chk("reset_data", 128'(bus.drain_data_o), 128'(0));
    chk("reset_flags", 128'({wrapped, triggered, order_err}), 128'(0));
    rst_n = 1'b1;
    cyc();
    cmp_en = 1;

    // Mode 1: stop on full after the 64th retirement.
    do_arm(2'd1);
    for (int i = 0; i < 70; i++) begin
      retire(32'h100 + 32'(4 * i), 64'(i));
      if (i == 62) chk("m1_capt_before_full", 128'(state), 128'(1));
      if (i == 63) chk("m1_stop_at_full", 128'(state), 128'(3));
    end
    chk("m1_count", 128'(count), 128'(64));
    drain_all(n, fpc, lpc, sok);
    chk("m1_drain_n", 128'(n), 128'(64));
    chk("m1_first_pc", 128'(fpc), 128'(32'h100));
    chk("m1_last_pc", 128'(lpc), 128'(32'h1FC));
    chk("m1_in_order", 128'(sok), 128'(1));
    chk("m1_valid_after", 128'(bus.drain_valid_o), 128'(0));

    // Mode 0: wrap, stop only on request.
    do_arm(2'd0);
    for (int i = 0; i < 100; i++) retire(32'h100 + 32'(4 * i), 64'(i));
    chk("m0_count", 128'(count), 128'(64));
    chk("m0_wrapped", 128'(wrapped), 128'(1));
    chk("m0_still_capt", 128'(state), 128'(1));
    stop = 1'b1; cyc(); stop = 1'b0;
    chk("m0_stopped", 128'(state), 128'(3));
    drain_all(n, fpc, lpc, sok);
    chk("m0_first_pc", 128'(fpc), 128'(32'h190));
    chk("m0_drain_n", 128'(n), 128'(64));

    // Mode 2: trigger on 0x200, three post entries.
    trig_pc = 32'h200; post_cnt = CW'(3); trig_on_trap = 1'b0;
    do_arm(2'd2);
    for (int i = 0; i < 68; i++) begin
      retire(32'h100 + 32'(4 * i), 64'(i));
      if (i == 64) chk("m2_in_post", 128'(state), 128'(2));
    end
    chk("m2_stop_after_20c", 128'(state), 128'(3));
    chk("m2_triggered", 128'(triggered), 128'(1));
    for (int i = 68; i < 72; i++) retire(32'h100 + 32'(4 * i), 64'(i));
    drain_all(n, fpc, lpc, sok);
    chk("m2_last_pc", 128'(lpc), 128'(32'h20C));
    chk("m2_first_pc", 128'(fpc), 128'(32'h110));

    // Drain with ready pattern 1,0,1,1 over three entries.
    do_arm(2'd1);
    for (int i = 0; i < 3; i++) retire(32'h400 + 32'(4 * i), 64'(i));
    stop = 1'b1; cyc(); stop = 1'b0;
    cyc();
    chk("tog_valid0", 128'(bus.drain_valid_o), 128'(1));
    bus.drain_ready_i = 1'b1;
    chk("tog_e0", 128'(bus.drain_data_o[95:64]), 128'(32'h400));
    cyc();
    bus.drain_ready_i = 1'b0;
    pa = bus.drain_data_o[95:64];
    chk("tog_e1_held", 128'(pa), 128'(32'h404));
    cyc();
    pb = bus.drain_data_o[95:64];
    chk("tog_stable", 128'(pb), 128'(pa));
    chk("tog_valid_held", 128'(bus.drain_valid_o), 128'(1));
    bus.drain_ready_i = 1'b1;
    cyc();
    chk("tog_e2", 128'(bus.drain_data_o[95:64]), 128'(32'h408));
    cyc();
    chk("tog_empty", 128'(bus.drain_valid_o), 128'(0));
    chk("tog_count", 128'(count), 128'(0));
    bus.drain_ready_i = 1'b0;

    // arm and stop together mid-POST.
    trig_pc = 32'h108; post_cnt = CW'(10);
    do_arm(2'd2);
    for (int i = 0; i < 5; i++) retire(32'h100 + 32'(4 * i), 64'(i));
    chk("as_post", 128'(state), 128'(2));
    arm = 1'b1; stop = 1'b1; cyc(); quiet();
    chk("as_capt", 128'(state), 128'(1));
    chk("as_count", 128'(count), 128'(0));
    chk("as_trig", 128'(triggered), 128'(0));

    // Retirement order gap.
    do_arm(2'd0);
    retire(32'h100, 64'd5);
    retire(32'h104, 64'd6);
    chk("ord_ok", 128'(order_err), 128'(0));
    retire(32'h108, 64'd8);
`ifdef IBEXC_TRACE_ORDER_CHK_EN
    chk("ord_gap", 128'(order_err), 128'(1));
`else
    chk("ord_gap_off", 128'(order_err), 128'(0));
`endif

    // Randomized rounds checked by the model.
    for (int r = 0; r < 40; r++) begin
      logic [63:0] ord;
      ord = 64'($urandom);
      trig_pc      = 32'h100 + 32'(4 * $urandom_range(0, 80));
      trig_on_trap = 1'($urandom_range(0, 1));
      post_cnt     = CW'($urandom_range(0, 8));
      do_arm(2'($urandom_range(0, 3)));
      for (int c = 0; c < 150; c++) begin
        if ($urandom_range(0, 9) < 7) begin
          ord = ord + (($urandom_range(0, 24) == 0) ? 64'd2 : 64'd1);
          set_ret(32'h100 + 32'(4 * $urandom_range(0, 80)), ord,
                  1'($urandom_range(0, 19) == 0));
        end else begin
          bus.rvfi_valid_i = 1'b0;
        end
        stop = 1'($urandom_range(0, 59) == 0);
        arm  = 1'($urandom_range(0, 299) == 0);
        bus.drain_ready_i = 1'($urandom_range(0, 1));
        cyc();
        quiet();
      end
      stop = 1'b1; cyc(); stop = 1'b0;
      for (int c = 0; c < 100; c++) begin
        bus.drain_ready_i = 1'($urandom_range(0, 3) != 0);
        arm = 1'($urandom_range(0, 199) == 0);
        cyc();
        arm = 1'b0;
      end
      bus.drain_ready_i = 1'b0;
    end

    cmp_en = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global runtime bound.
  initial begin
    #2000000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/ibexc_rvfi_trace_buffer.md
Name: ibexc_rvfi_trace_buffer

Overview:
- Capture block for the RVFI retirement stream of the CHERIoT Ibex core, placed beside the tracer in the tracing top level.
- Records retired instructions into a parametrised circular buffer.
- Supports continuous, stop-on-full and trigger-with-post-count capture modes.
- When capture is stopped, the buffer is drained oldest-first over a valid/ready port for on-chip debug readout.

Parameters:
- Depth, 64: buffer entries; power of 2, range 4..1024.
- PostTrigDefault, 16: post-trigger entry count used when post_cnt_i == 0.
- CntW, $clog2(Depth)+1: width of count_o.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset; asynchronous, active-low.
- rvfi_valid_i  in  1  retirement strobe.
- rvfi_order_i  in  64  retirement order.
- rvfi_pc_rdata_i  in  32  retired PC.
- rvfi_insn_i  in  32  instruction word.
- rvfi_trap_i  in  1  trap flag.
- rvfi_intr_i  in  1  interrupt-entry flag.
- rvfi_rd_addr_i  in  5  destination register.
- rvfi_rd_wdata_i  in  32  destination data.
- arm_i  in  1  pulse: clear buffer, start capture.
- stop_i  in  1  pulse: force stop.
- mode_i  in  2  0 = continuous wrap, 1 = stop-on-full, 2 = trigger, 3 = reserved (treated as 0).
- trig_pc_i  in  32  trigger PC.
- trig_on_trap_i  in  1  a trap also triggers.
- post_cnt_i  in  CntW  post-trigger entries.
- drain_valid_o  out  1  entry available.
- drain_ready_i  in  1  consumer accepts.
- drain_data_o  out  103  entry: {trap, intr, rd_addr, pc, insn, rd_wdata}.
- count_o  out  CntW  valid entries held.
- state_o  out  2  0 = IDLE, 1 = CAPT, 2 = POST, 3 = STOP.
- wrapped_o  out  1  sticky: an entry was overwritten.
- triggered_o  out  1  sticky: trigger fired.
- order_err_o  out  1  sticky: retirement order gap (optional feature).

Behaviour:
- Reset: state IDLE; write pointer, read pointer and count = 0. All outputs 0, drain_data_o included.
- IDLE: no capture.
  - arm_i → CAPT next cycle; pointers, count and sticky flags cleared on the same edge.
- CAPT: each rvfi_valid_i writes one entry at the write pointer (no gaps, one entry per cycle max).
  - Write pointer increments modulo Depth; count saturates at Depth.
  - Mode 0, full: oldest entry overwritten, read pointer advances, wrapped_o set.
  - Mode 1: when count reaches Depth → STOP; later retirements are ignored.
  - Mode 2: trigger = rvfi_valid_i && (pc == trig_pc_i || (trig_on_trap_i && trap)).
    - The triggering entry is written, triggered_o set, post counter loaded with post_cnt_i (PostTrigDefault if 0), state → POST.
    - Overwrite on full as in mode 0.
- POST: each captured entry decrements the post counter.
  - When it reaches 0 on a write → STOP; that entry is included.
  - post_cnt_i is sampled only at the trigger.
- stop_i in CAPT or POST → STOP; a retirement in the same cycle is still written.
- arm_i in any state restarts capture (clears pointers and flags); arm_i takes priority over a simultaneous stop_i.
- STOP and IDLE: drain enabled.
  - Data comes from a registered RAM read: drain_valid_o asserts 1 cycle after entry to STOP when count > 0.
  - Transfer on drain_valid_o && drain_ready_i: read pointer and count advance, next entry valid the following cycle.
  - Back-to-back transfers with drain_ready_i held high: one entry per cycle after the first-cycle latency, via a prefetch register.
  - count == 0: drain_valid_o = 0.
  - drain_data_o stable while valid && !ready.
- Draining never happens in CAPT or POST (drain_valid_o = 0).
- arm_i mid-drain: drain_valid_o drops next cycle; any pending entry is discarded.
- Storage is inferred RAM; there is no reset on RAM contents.

Optional Feature:
- Macro: IBEXC_TRACE_ORDER_CHK_EN.
- Defined: a 64-bit last_order register is kept.
  - While in CAPT or POST, a retirement with rvfi_order_i != last_order+1 sets order_err_o. The first retirement after arm is exempt.
  - Cleared by arm_i or reset.
- Not defined: order_err_o tied 0; no order register.

Test Plan:
- Mode 1, Depth=64, 70 retirements with PCs 0x100+4n → state STOP after 64th; count_o=64; drain yields PCs 0x100..0x1FC in order, then drain_valid_o=0.
- Mode 0, Depth=64, 100 retirements → count_o=64, wrapped_o=1; first drained PC = 0x100+4·36 = 0x190; stop_i required to enter STOP.
- Mode 2, trig_pc_i=0x200, post_cnt_i=3, sequential PCs from 0x100 → triggered_o=1; STOP after PC 0x20C; last drained entry PC=0x20C.
- Drain with drain_ready_i toggled 1,0,1,1 over 3 entries → 3 unique entries, no duplicates or losses; data stable while ready=0.
- arm_i and stop_i asserted together mid-POST → state CAPT next cycle; count_o=0, triggered_o=0.
- With IBEXC_TRACE_ORDER_CHK_EN: orders 5,6,8 → order_err_o=1 after order 8. Without the macro, order_err_o stays 0.
